moore_sd: RTL and testbench

- Moore-type serial sequence detector.
- Samples a 1-bit serial stream `in` on each rising clock edge and asserts `out` for one full cycle after the final bit of the target pattern is received.
- Default pattern is 1011 with overlapping matches allowed.
- Sits on a serial input path as a pattern-match flag generator; `out` is decoded from state only and never from `in` directly.

---
 rtl/moore_sd_if.sv | 12 +
 rtl/moore_sd.sv | 96 +++++++++
 tb/tb_moore_sd.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/moore_sd_if.sv
// Serial stream interface for the Moore sequence detector.
// Stream semantics: there is no valid/ready pair. `in` carries one data bit
// per rising clock edge, and every edge is a sample. `out` is the registered
// match flag. It is high for the cycle after the edge that sampled the final
// pattern bit.
interface moore_sd_if;
  logic in;
  logic out;

  modport master (output in, input out);
  modport slave  (input in, output out);
endinterface

// File: rtl/moore_sd.sv
// Moore serial sequence detector. The state holds the length of the longest
// pattern prefix that matches the most recent input bits. The flag is decoded
// from the state only, so it never depends on `in` combinationally.
module moore_sd #(
  parameter int                     PATTERN_LEN = 4,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1011,
  parameter bit                     OVERLAP     = 1'b1,
  localparam int                    SW          = $clog2(PATTERN_LEN + 1)
) (
  input  logic          clk,
  input  logic          clear,
  moore_sd_if.slave     bus,
  output logic [SW-1:0] dbg_state
);

  localparam logic [SW-1:0] LAST = SW'(PATTERN_LEN);

  typedef enum logic [SW-1:0] {
    S_IDLE = '0,
    S_DONE = LAST
  } state_t;

  // Next state from prefix length k on input bit b. The first pattern bit
  // is PATTERN[PATTERN_LEN-1]. On a mismatch, or from the full-match state
  // with overlap, the function searches for the longest prefix that is a
  // suffix of (matched prefix, b). This is the KMP fallback.
  function automatic int next_state(input int k, input bit b);
    int  l;
    int  idx;
    int  best;
    bit  ok;
    bit  sb;
    if (k < PATTERN_LEN) begin
      if (b == PATTERN[PATTERN_LEN-1-k]) return k + 1;
    end else if (!OVERLAP) begin
      return (b == PATTERN[PATTERN_LEN-1]) ? 1 : 0;
    end
    l    = k + 1;
    best = 0;
    for (int j = 1; j <= PATTERN_LEN; j++) begin
      if (j <= l) begin
        ok = 1'b1;
        for (int i = 0; i < PATTERN_LEN; i++) begin
          if (i < j) begin
            idx = l - j + i;
            if (idx < k) sb = PATTERN[PATTERN_LEN-1-idx];
            else         sb = b;
            if (PATTERN[PATTERN_LEN-1-i] != sb) ok = 1'b0;
          end
        end
        if (ok) best = j;
      end
    end
    return best;
  endfunction

  // The transition table is fixed when the design is elaborated. Each entry
  // is a constant driven from the parameters.
  logic [SW-1:0] nxt_tbl [PATTERN_LEN+1][2];

  for (genvar k = 0; k <= PATTERN_LEN; k++) begin : g_st
    for (genvar b = 0; b < 2; b++) begin : g_in
      assign nxt_tbl[k][b] = SW'(next_state(k, (b != 0)));
    end
  end

  state_t state_q, state_d;
  logic   out_q, out_d;

  // Next-state lookup. An encoding above S_DONE falls back to idle.
  // The flag is decoded from the next state, so it registers together
  // with the state.
  always_comb begin
    state_d = S_IDLE;
    out_d   = 1'b0;
    if (state_q <= LAST) begin
      state_d = state_t'(nxt_tbl[state_q][bus.in]);
    end
    out_d = (state_d == S_DONE);
  end

  // State and flag registers. Clear forces idle immediately.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= S_IDLE;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  assign bus.out   = out_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_moore_sd.sv
// Bench for moore_sd. It drives the same stream into an overlapping
// instance and a non-overlapping instance of the default 1011 detector.
// A history-based model checks both instances on every cycle. Directed
// sequences add literal expectations.
module tb_moore_sd;

  localparam int              N   = 4;
  localparam logic [N-1:0]    PAT = 4'b1011;

  logic       clk;
  logic       clear;
  logic       din;
  logic [2:0] dbg_ov;
  logic [2:0] dbg_no;

  int total = 0;
  int bad   = 0;

  moore_sd_if bus_ov ();
  moore_sd_if bus_no ();

  assign bus_ov.in = din;
  assign bus_no.in = din;

  moore_sd #(.PATTERN_LEN(N), .PATTERN(PAT), .OVERLAP(1'b1)) u_dut_ov (
    .clk       (clk),
    .clear     (clear),
    .bus       (bus_ov.slave),
    .dbg_state (dbg_ov)
  );

  moore_sd #(.PATTERN_LEN(N), .PATTERN(PAT), .OVERLAP(1'b0)) u_dut_no (
    .clk       (clk),
    .clear     (clear),
    .bus       (bus_no.slave),
    .dbg_state (dbg_no)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a detection is when the last N bits received equal the pattern.
  // Without overlap, the history restarts after each detection.
  logic hist_ov[$];
  logic hist_no[$];
  logic exp_ov = 1'b0;
  logic exp_no = 1'b0;

  function automatic logic tail_match(input logic h[$]);
    if (h.size() < N) return 1'b0;
    for (int i = 0; i < N; i++) begin
      if (h[h.size()-N+i] !== PAT[N-1-i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clear) begin
    hist_ov.delete();
    hist_no.delete();
    exp_ov = 1'b0;
    exp_no = 1'b0;
  end

  // Per-cycle compare against the model.
  always @(posedge clk) begin
    if (clear) begin
      hist_ov.delete();
      hist_no.delete();
      exp_ov = 1'b0;
      exp_no = 1'b0;
    end else begin
      hist_ov.push_back(din);
      if (hist_ov.size() > N) void'(hist_ov.pop_front());
      exp_ov = tail_match(hist_ov);
      hist_no.push_back(din);
      if (hist_no.size() > N) void'(hist_no.pop_front());
      exp_no = tail_match(hist_no);
      if (exp_no) hist_no.delete();
    end
    #1;
    check("model_ov", bus_ov.out, exp_ov);
    check("model_no", bus_no.out, exp_no);
  end

  // Drive one bit, then sample after the edge.
  task automatic step(input logic b);
    @(negedge clk);
    din = b;
    @(posedge clk);
    #2;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    din   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic run_seq(input string name, input logic [15:0] bits, input int n,
                         input logic [15:0] e_ov, input logic [15:0] e_no);
    logic [15:0] bv;
    logic [15:0] ev_ov;
    logic [15:0] ev_no;
    bv    = bits;
    ev_ov = e_ov;
    ev_no = e_no;
    for (int i = 0; i < n; i++) begin
      step(bv[n-1-i]);
      check({name, "_ov"}, bus_ov.out, ev_ov[n-1-i]);
      check({name, "_no"}, bus_no.out, ev_no[n-1-i]);
    end
  endtask

  task automatic async_clear_check(input string name);
    #1;
    clear = 1'b1;
    #1;
    check({name, "_ov"}, bus_ov.out, 1'b0);
    check({name, "_no"}, bus_no.out, 1'b0);
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    clear = 1'b1;
    din   = 1'b0;
    @(posedge clk);
    #2;
    check("reset_ov", bus_ov.out, 1'b0);
    check("reset_no", bus_no.out, 1'b0);
    @(negedge clk);
    clear = 1'b0;
    step(1'b0);
    check("idle_ov", bus_ov.out, 1'b0);
    check("idle_no", bus_no.out, 1'b0);

    run_seq("basic",    16'b1011,       4,  16'b0001,       16'b0001);
    do_clear();
    run_seq("stream",   16'b1011001011, 10, 16'b0001000001, 16'b0001000001);
    do_clear();
    run_seq("overlap",  16'b1011011,    7,  16'b0001001,    16'b0001000);
    do_clear();
    run_seq("nearmiss", 16'b11011,      5,  16'b00001,      16'b00001);
    do_clear();
    run_seq("nomatch",  16'b10011,      5,  16'b00000,      16'b00000);
    do_clear();
    run_seq("fallback", 16'b101011,     6,  16'b000001,     16'b000001);
    do_clear();

    // Raise clear between edges while the flag is high.
    run_seq("pre_clr",  16'b1011,       4,  16'b0001,       16'b0001);
    async_clear_check("async_clr");
    run_seq("post_clr", 16'b11,         2,  16'b00,         16'b00);

    // Random stream with occasional mid-cycle clears.
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 99) < 2) begin
        async_clear_check("rand_clr");
      end else begin
        step(1'($urandom_range(0, 1)));
      end
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
